// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and its read-side packer.
// Defaults here keep the FIFO and the packer agreeing on word width.
package fifo_pkg;

  // Default FIFO word width and address width.
  localparam int DSIZE_DEF = 6;
  localparam int ASIZE_DEF = 4;

  // Default number of FIFO words packed into one output word.
  localparam int PACK_DEF = 4;

  // Width of a field able to hold any count 0..pack inclusive.
  function automatic int cnt_width(input int pack);
    return $clog2(pack + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Read-side packer for the async FIFO. Lives entirely in the rclk domain,
// pops show-ahead FIFO words and packs PACK of them (word 0 in the LSBs)
// into one wide word on a valid/ready stream. A flush pulse emits any
// partially filled word together with its word count.
//
// Handshake: an output word transfers on an rclk edge where m_valid and
// m_ready are both high; while m_valid=1 and m_ready=0, m_data and m_cnt
// hold stable. The FIFO side pops on every edge where rinc=1, and rinc is
// only raised while rempty=0.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int PACK  = PACK_DEF,
  parameter int CNTW  = cnt_width(PACK)
) (
  input  logic                    rclk,
  input  logic                    rrst,
  input  logic [DSIZE-1:0]        rdata,
  input  logic                    rempty,
  output logic                    rinc,
  input  logic                    flush,
  output logic [DSIZE*PACK-1:0]   m_data,
  output logic [CNTW-1:0]         m_cnt,
  output logic                    m_valid,
  input  logic                    m_ready
);

  localparam int WW = DSIZE * PACK;

  // Accumulator and its fill level (0..PACK words).
  logic [WW-1:0]   r_acc;
  logic [CNTW-1:0] r_fill;
  // Set by a flush request; blocks pops until the partial word has gone.
  logic            r_flush_pend;

  // Output register.
  logic [WW-1:0]   r_m_data;
  logic [CNTW-1:0] r_m_cnt;
  logic            r_m_valid;

  // Combinational control.
  logic            w_full;
  logic            w_slot_free;
  logic            w_xfer;
  logic            w_pop;
  logic [CNTW-1:0] w_lane;
  logic [WW-1:0]   w_acc_next;
  logic [CNTW-1:0] w_fill_next;
  logic            w_flush_pend_next;

  // The output slot can take a new word when empty or being drained now.
  assign w_full      = (r_fill == CNTW'(PACK));
  assign w_slot_free = !r_m_valid || m_ready;

  // Move the accumulator to the output register: a complete word, or a
  // non-empty partial word while a flush is pending.
  assign w_xfer = w_slot_free && (w_full || (r_flush_pend && (r_fill != '0)));

  // Pop while there is room in the accumulator (or room is being made on
  // this very edge). Forced low during reset so the FIFO never sees a pop
  // the packer did not capture.
  assign w_pop = !rrst && !rempty && !r_flush_pend &&
                 ((r_fill < CNTW'(PACK)) || w_xfer);
  assign rinc  = w_pop;

  // A pop that coincides with a transfer lands in lane 0 of the fresh word.
  assign w_lane = w_xfer ? '0 : r_fill;

  // Next accumulator contents: cleared on transfer so unused upper lanes of
  // a partial word read as zero, then the popped word written to its lane.
  always_comb begin
    w_acc_next = w_xfer ? '0 : r_acc;
    if (w_pop) begin
      for (int i = 0; i < PACK; i++) begin
        if (w_lane == CNTW'(i)) begin
          w_acc_next[i*DSIZE +: DSIZE] = rdata;
        end
      end
    end
  end

  // Next fill level: emptied by a transfer, bumped by a pop.
  always_comb begin
    w_fill_next = r_fill;
    if (w_xfer) begin
      w_fill_next = '0;
    end
    if (w_pop) begin
      w_fill_next = w_lane + CNTW'(1);
    end
  end

  // Flush tracking: a new request is taken only when none is pending; a
  // pending flush retires once the accumulator has been emptied, either by
  // a transfer or because there was nothing to send.
  always_comb begin
    w_flush_pend_next = r_flush_pend;
    if (r_flush_pend) begin
      if (w_xfer || (r_fill == '0)) begin
        w_flush_pend_next = 1'b0;
      end
    end else begin
      w_flush_pend_next = flush;
    end
  end

  // Accumulator, fill level and flush flag registers.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_acc        <= '0;
      r_fill       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_acc        <= w_acc_next;
      r_fill       <= w_fill_next;
      r_flush_pend <= w_flush_pend_next;
    end
  end

  // Output register: loads on transfer, drops valid after a handshake with
  // nothing new to send, otherwise holds under backpressure.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_m_data  <= '0;
      r_m_cnt   <= '0;
      r_m_valid <= 1'b0;
    end else if (w_xfer) begin
      r_m_data  <= r_acc;
      r_m_cnt   <= r_fill;
      r_m_valid <= 1'b1;
    end else if (w_slot_free) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_data  = r_m_data;
  assign m_cnt   = r_m_cnt;
  assign m_valid = r_m_valid;

endmodule
